// File: rtl/psum_shift_acc_pkg.sv
// Shared widths, state encoding and tag bundle for the bit-serial
// partial-sum shift accumulator.
package psum_shift_acc_pkg;

    localparam int BITS_SIP_DOT_ADDER = 8;
    localparam int MAX_PREC   = 8;
    localparam int PREC_W     = $clog2(MAX_PREC);
    localparam int SHIFT_W    = PREC_W + 1;
    localparam int PSUM_W_DEF = BITS_SIP_DOT_ADDER;
    localparam int ACC_W_DEF  = PSUM_W_DEF + 2 * (MAX_PREC - 1) + 2;
    localparam int OUT_W_DEF  = 16;
    localparam int PE_LAT_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [SHIFT_W-1:0] shift;
        logic               last;
    } tag_t;

endpackage

// File: rtl/psum_shift_acc_tag_pipe.sv
// psum_tag_pipe: DEPTH-stage register chain of {valid, shift, last}
// tags that tracks each issued plane pair until its psum arrives.
module psum_tag_pipe
    import psum_shift_acc_pkg::*;
#(
    parameter int DEPTH = PE_LAT_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/psum_shift_acc.sv
// Bit-plane sequencer and shift accumulator behind a 1-bit PE.
// Define PSUM_ACC_SAT_EN to saturate o_result instead of truncating.
module psum_shift_acc
    import psum_shift_acc_pkg::*;
#(
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int PE_LAT = PE_LAT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_start,
    input  logic [2:0]        i_act_prec,
    input  logic [2:0]        i_w_prec,
    input  logic              i_signed_act,
    input  logic              i_signed_w,
    output logic              o_issue_valid,
    output logic [2:0]        o_act_bit,
    output logic [2:0]        o_w_bit,
    output logic              o_SignI,
    output logic              o_SignW,
    input  logic              i_psum_valid,
    input  logic [PSUM_W-1:0] i_psum,
    output logic              o_busy,
    output logic              o_valid,
    output logic [OUT_W-1:0]  o_result,
    output logic              o_err
);

    state_t r_state, w_next;
    logic [PREC_W-1:0] r_ap, r_wp, r_act, r_w;
    logic r_sa, r_sw, r_err;
    logic signed [ACC_W-1:0] r_acc, w_acc_next, w_term, w_ext;
    logic [OUT_W-1:0] r_result, w_res;
    logic w_issue, w_act_end, w_last_issue;
    logic w_consume, w_final;
    tag_t w_tag_in, w_tag_out;

    assign w_issue      = (r_state == ST_ISSUE);
    assign w_act_end    = (r_act == r_ap);
    assign w_last_issue = w_issue && w_act_end && (r_w == r_wp);
    assign w_consume    = w_tag_out.valid;
    assign w_final      = w_consume && w_tag_out.last;

    always_comb begin
        w_tag_in       = '0;
        w_tag_in.valid = w_issue;
        w_tag_in.shift = SHIFT_W'(r_act) + SHIFT_W'(r_w);
        w_tag_in.last  = w_last_issue;
    end

    psum_tag_pipe #(
        .DEPTH (PE_LAT)
    ) u_tag_pipe (
        .CLK   (CLK),
        .RST   (RST),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    // A missing psum contributes nothing; o_err records the loss.
    assign w_ext = {{(ACC_W-PSUM_W){i_psum[PSUM_W-1]}}, i_psum};

    always_comb begin
        w_term = '0;
        if (w_consume && i_psum_valid) begin
            w_term = w_ext <<< w_tag_out.shift;
        end
        w_acc_next = r_acc + w_term;
    end

`ifdef PSUM_ACC_SAT_EN
    always_comb begin
        w_res = w_acc_next[OUT_W-1:0];
        if (w_acc_next[ACC_W-1:OUT_W-1] !=
            {(ACC_W-OUT_W+1){w_acc_next[ACC_W-1]}}) begin
            w_res = w_acc_next[ACC_W-1] ?
                    {1'b1, {(OUT_W-1){1'b0}}} :
                    {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign w_res = w_acc_next[OUT_W-1:0];
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_ISSUE;
            ST_ISSUE: if (w_last_issue) w_next = ST_DRAIN;
            ST_DRAIN: if (w_final) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_ap     <= '0;
            r_wp     <= '0;
            r_act    <= '0;
            r_w      <= '0;
            r_sa     <= 1'b0;
            r_sw     <= 1'b0;
            r_err    <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && i_start) begin
                r_ap  <= i_act_prec;
                r_wp  <= i_w_prec;
                r_sa  <= i_signed_act;
                r_sw  <= i_signed_w;
                r_act <= '0;
                r_w   <= '0;
                r_acc <= '0;
                r_err <= 1'b0;
            end
            if (w_issue) begin
                if (w_act_end) begin
                    r_act <= '0;
                    r_w   <= w_last_issue ? '0 : r_w + 1'b1;
                end else begin
                    r_act <= r_act + 1'b1;
                end
            end
            if (w_consume) begin
                r_acc <= w_acc_next;
                if (!i_psum_valid) r_err <= 1'b1;
            end
            if (w_final) r_result <= w_res;
        end
    end

    assign o_issue_valid = w_issue;
    assign o_act_bit     = w_issue ? r_act : '0;
    assign o_w_bit       = w_issue ? r_w : '0;
    assign o_SignI       = w_issue && r_sa && w_act_end;
    assign o_SignW       = w_issue && r_sw && (r_w == r_wp);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_valid       = (r_state == ST_DONE);
    assign o_result      = r_result;
    assign o_err         = r_err;

endmodule

// File: tb/tb_psum_shift_acc.sv
// Directed bench for psum_shift_acc: a PE stand-in feeds psums one
// cycle after each issue; expected values are hand-computed.
module tb_psum_shift_acc;

    logic        CLK = 1'b0;
    logic        RST;
    logic        i_start;
    logic [2:0]  i_act_prec;
    logic [2:0]  i_w_prec;
    logic        i_signed_act;
    logic        i_signed_w;
    logic        o_issue_valid;
    logic [2:0]  o_act_bit;
    logic [2:0]  o_w_bit;
    logic        o_SignI;
    logic        o_SignW;
    logic        i_psum_valid;
    logic [7:0]  i_psum;
    logic        o_busy;
    logic        o_valid;
    logic [15:0] o_result;
    logic        o_err;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] g_ps [64];
    logic       ob_iv [64];
    logic [2:0] ob_act [64];
    logic [2:0] ob_w [64];
    logic       ob_si [64];
    logic       ob_sw [64];
    logic       ob_drain_iv, ob_drain_valid;
    logic       ob_done_valid, ob_done_err, ob_done_busy;
    logic [15:0] ob_done_res, ob_after_res;
    logic       ob_after_valid, ob_after_busy;

    psum_shift_acc dut (
        .CLK           (CLK),
        .RST           (RST),
        .i_start       (i_start),
        .i_act_prec    (i_act_prec),
        .i_w_prec      (i_w_prec),
        .i_signed_act  (i_signed_act),
        .i_signed_w    (i_signed_w),
        .o_issue_valid (o_issue_valid),
        .o_act_bit     (o_act_bit),
        .o_w_bit       (o_w_bit),
        .o_SignI       (o_SignI),
        .o_SignW       (o_SignW),
        .i_psum_valid  (i_psum_valid),
        .i_psum        (i_psum),
        .o_busy        (o_busy),
        .o_valid       (o_valid),
        .o_result      (o_result),
        .o_err         (o_err)
    );

    always #5 CLK = ~CLK;

    // Runs one job and records what the DUT showed; no checking here.
    task automatic do_job(input int ap, input int wp,
                          input bit sa, input bit sw,
                          input int drop, input bit mid);
        int n;
        logic [2:0] a3, w3;
        n  = (ap + 1) * (wp + 1);
        a3 = ap[2:0];
        w3 = wp[2:0];
        @(negedge CLK);
        i_start      = 1'b1;
        i_act_prec   = a3;
        i_w_prec     = w3;
        i_signed_act = sa;
        i_signed_w   = sw;
        @(posedge CLK);
        #1;
        i_start      = 1'b0;
        i_act_prec   = ~a3;
        i_w_prec     = ~w3;
        i_signed_act = ~sa;
        i_signed_w   = ~sw;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            ob_iv[k]  = o_issue_valid;
            ob_act[k] = o_act_bit;
            ob_w[k]   = o_w_bit;
            ob_si[k]  = o_SignI;
            ob_sw[k]  = o_SignW;
            @(posedge CLK);
            #1;
            i_psum       = g_ps[k];
            i_psum_valid = (k != drop);
            i_start      = mid && (k == 0);
        end
        @(negedge CLK);
        i_start        = 1'b0;
        ob_drain_iv    = o_issue_valid;
        ob_drain_valid = o_valid;
        @(posedge CLK);
        #1;
        i_psum       = 8'h55;
        i_psum_valid = 1'b1;
        @(negedge CLK);
        ob_done_valid = o_valid;
        ob_done_res   = o_result;
        ob_done_err   = o_err;
        ob_done_busy  = o_busy;
        @(posedge CLK);
        #1;
        i_psum       = 8'h00;
        i_psum_valid = 1'b0;
        @(negedge CLK);
        ob_after_valid = o_valid;
        ob_after_busy  = o_busy;
        ob_after_res   = o_result;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        nvec++;
        if ({o_issue_valid, o_valid, o_busy, o_err, o_SignI, o_SignW}
            !== 6'b0) begin
            nerr++;
            $display("FAIL reset_flags: got %b want 000000",
                {o_issue_valid, o_valid, o_busy, o_err, o_SignI, o_SignW});
        end
        nvec++;
        if ({o_act_bit, o_w_bit} !== 6'b0) begin
            nerr++;
            $display("FAIL reset_bits: got %b want 000000",
                {o_act_bit, o_w_bit});
        end
        nvec++;
        if (o_result !== 16'h0) begin
            nerr++;
            $display("FAIL reset_result: got %h want 0000", o_result);
        end
    endtask

    task automatic test_single();
        g_ps[0] = 8'd5;
        do_job(0, 0, 1'b0, 1'b0, -1, 1'b0);
        nvec++;
        if ({ob_iv[0], ob_act[0], ob_w[0], ob_si[0], ob_sw[0]}
            !== 9'b1_000_000_00) begin
            nerr++;
            $display("FAIL single_issue: got %b want 100000000",
                {ob_iv[0], ob_act[0], ob_w[0], ob_si[0], ob_sw[0]});
        end
        nvec++;
        if ({ob_drain_iv, ob_drain_valid} !== 2'b00) begin
            nerr++;
            $display("FAIL single_drain: got %b want 00",
                {ob_drain_iv, ob_drain_valid});
        end
        nvec++;
        if ({ob_done_valid, ob_done_busy, ob_done_err} !== 3'b110) begin
            nerr++;
            $display("FAIL single_done_flags: got %b want 110",
                {ob_done_valid, ob_done_busy, ob_done_err});
        end
        nvec++;
        if (ob_done_res !== 16'd5) begin
            nerr++;
            $display("FAIL single_result: got %h want 0005", ob_done_res);
        end
        nvec++;
        if ({ob_after_valid, ob_after_busy, ob_after_res}
            !== {2'b00, 16'd5}) begin
            nerr++;
            $display("FAIL single_after: got %b %h want 00 0005",
                {ob_after_valid, ob_after_busy}, ob_after_res);
        end
    endtask

    task automatic test_unsigned_2x2();
        for (int k = 0; k < 4; k++) g_ps[k] = 8'd1;
        do_job(1, 1, 1'b0, 1'b0, -1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            nvec++;
            if ({ob_iv[k], ob_act[k], ob_w[k], ob_si[k], ob_sw[k]} !==
                {1'b1, 3'(k % 2), 3'(k / 2), 2'b00}) begin
                nerr++;
                $display("FAIL u2x2_issue%0d: got %b want %b", k,
                    {ob_iv[k], ob_act[k], ob_w[k], ob_si[k], ob_sw[k]},
                    {1'b1, 3'(k % 2), 3'(k / 2), 2'b00});
            end
        end
        nvec++;
        if ({ob_done_valid, ob_done_res} !== {1'b1, 16'd9}) begin
            nerr++;
            $display("FAIL u2x2_result: got %b %h want 1 0009",
                ob_done_valid, ob_done_res);
        end
    endtask

    task automatic test_signed_act();
        g_ps[0] = 8'd0;
        g_ps[1] = 8'd0;
        g_ps[2] = 8'd0;
        g_ps[3] = 8'hFD;
        do_job(1, 1, 1'b1, 1'b0, -1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            nvec++;
            if ({ob_si[k], ob_sw[k]} !== {1'(k % 2), 1'b0}) begin
                nerr++;
                $display("FAIL sact_sign%0d: got %b want %b", k,
                    {ob_si[k], ob_sw[k]}, {1'(k % 2), 1'b0});
            end
        end
        nvec++;
        if (ob_done_res !== 16'hFFF4) begin
            nerr++;
            $display("FAIL sact_result: got %h want fff4", ob_done_res);
        end
    endtask

    task automatic test_full_prec();
        logic [15:0] exp_res;
        int bad;
`ifdef PSUM_ACC_SAT_EN
        exp_res = 16'h7FFF;
`else
        exp_res = 16'h027F;
`endif
        for (int k = 0; k < 64; k++) g_ps[k] = 8'd127;
        do_job(7, 7, 1'b0, 1'b0, -1, 1'b0);
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if ({ob_iv[k], ob_act[k], ob_w[k]} !==
                {1'b1, 3'(k % 8), 3'(k / 8)}) bad++;
        end
        nvec++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL full_order: got %0d bad issues want 0", bad);
        end
        nvec++;
        if ({ob_drain_iv, ob_done_valid, ob_done_res}
            !== {2'b01, exp_res}) begin
            nerr++;
            $display("FAIL full_result: got %b %h want 01 %h",
                {ob_drain_iv, ob_done_valid}, ob_done_res, exp_res);
        end
    endtask

    task automatic test_missing_psum();
        for (int k = 0; k < 4; k++) g_ps[k] = 8'd1;
        do_job(1, 1, 1'b0, 1'b0, 1, 1'b0);
        nvec++;
        if ({ob_done_err, ob_done_res} !== {1'b1, 16'd7}) begin
            nerr++;
            $display("FAIL missing_psum: got %b %h want 1 0007",
                ob_done_err, ob_done_res);
        end
    endtask

    task automatic test_start_in_issue();
        g_ps[0] = 8'd3;
        g_ps[1] = 8'd5;
        do_job(1, 0, 1'b0, 1'b0, -1, 1'b1);
        nvec++;
        if ({ob_iv[0], ob_iv[1], ob_drain_iv} !== 3'b110) begin
            nerr++;
            $display("FAIL start_ign_issue: got %b want 110",
                {ob_iv[0], ob_iv[1], ob_drain_iv});
        end
        nvec++;
        if ({ob_done_err, ob_done_res} !== {1'b0, 16'd13}) begin
            nerr++;
            $display("FAIL start_ign_result: got %b %h want 0 000d",
                ob_done_err, ob_done_res);
        end
    endtask

    task automatic test_reset_in_drain();
        int seen;
        @(negedge CLK);
        i_start      = 1'b1;
        i_act_prec   = 3'd1;
        i_w_prec     = 3'd1;
        i_signed_act = 1'b0;
        i_signed_w   = 1'b0;
        @(posedge CLK);
        #1;
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK);
            #1;
            i_psum       = 8'd1;
            i_psum_valid = 1'b1;
        end
        RST = 1'b1;
        @(negedge CLK);
        nvec++;
        if ({o_busy, o_issue_valid, o_valid} !== 3'b100) begin
            nerr++;
            $display("FAIL rst_drain_state: got %b want 100",
                {o_busy, o_issue_valid, o_valid});
        end
        @(posedge CLK);
        #1;
        RST          = 1'b0;
        i_psum_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge CLK);
            if (o_valid !== 1'b0 || o_busy !== 1'b0) seen++;
        end
        nvec++;
        if (seen != 0) begin
            nerr++;
            $display("FAIL rst_drain_quiet: got %0d active cycles want 0",
                seen);
        end
        for (int k = 0; k < 4; k++) g_ps[k] = 8'd1;
        do_job(1, 1, 1'b0, 1'b0, -1, 1'b0);
        nvec++;
        if ({ob_done_valid, ob_done_err, ob_done_res}
            !== {2'b10, 16'd9}) begin
            nerr++;
            $display("FAIL rst_drain_next: got %b %h want 10 0009",
                {ob_done_valid, ob_done_err}, ob_done_res);
        end
    endtask

    initial begin
        RST          = 1'b1;
        i_start      = 1'b0;
        i_act_prec   = 3'd0;
        i_w_prec     = 3'd0;
        i_signed_act = 1'b0;
        i_signed_w   = 1'b0;
        i_psum_valid = 1'b0;
        i_psum       = 8'd0;
        test_reset();
        test_single();
        test_unsigned_2x2();
        test_signed_act();
        test_full_prec();
        test_missing_psum();
        test_start_in_issue();
        test_reset_in_drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
